// File: rtl/bf_result_dumper.sv
// Post-run result drain for the Bellman-Ford engine.
// A rising edge on Finish starts a scan of output memory. Each entry goes out as one
// (address, distance, INF-flag) record on a valid/ready stream. When NegCycle is set at
// the trigger, a single negative-cycle record is sent instead and memory is not read.
module bf_result_dumper #(
  parameter int                 DATA_W   = 16,
  parameter int                 ADDR_W   = 13,
  parameter int                 DEPTH    = 8192,
  parameter logic [DATA_W-1:0]  INF_CODE = {DATA_W{1'b1}},
  parameter int                 RD_LAT   = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              Finish,
  input  logic              NegCycle,
  output logic [ADDR_W-1:0] OMAR,
  input  logic [DATA_W-1:0] OMDR,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_inf,
  output logic              out_neg,
  output logic              out_last,
  output logic [ADDR_W:0]   reach_count,
  output logic              busy,
  output logic              done
);

  // The last entry is DEPTH-1. With DEPTH = 2**ADDR_W this is all-ones, so the
  // address register reaches it without wrapping.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WT,
    S_CAP,
    S_SEND,
    S_NEG,
    S_DONE
  } state_t;

  state_t state;
  logic   finish_q;
  // armed is clear for the first edge after reset. This ensures that a Finish level
  // already high when reset releases is not mistaken for a rising edge.
  logic   armed;
  logic   trigger;
  logic   xfer;

  assign trigger = Finish & ~finish_q & armed;
  assign xfer    = out_valid & out_ready;

  // Drain sequencer. OMAR doubles as the scan address register, so it holds its value
  // in every state that does not advance the scan.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      finish_q    <= 1'b0;
      armed       <= 1'b0;
      OMAR        <= '0;
      out_valid   <= 1'b0;
      out_addr    <= '0;
      out_data    <= '0;
      out_inf     <= 1'b0;
      out_neg     <= 1'b0;
      out_last    <= 1'b0;
      reach_count <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      finish_q <= Finish;
      armed    <= 1'b1;
      case (state)
        S_IDLE, S_DONE: begin
          if (trigger) begin
            reach_count <= '0;
            done        <= 1'b0;
            busy        <= 1'b1;
            if (NegCycle) begin
              state     <= S_NEG;
              out_valid <= 1'b1;
              out_addr  <= '0;
              out_data  <= '0;
              out_inf   <= 1'b0;
              out_neg   <= 1'b1;
              out_last  <= 1'b1;
            end else begin
              state <= S_RD;
              OMAR  <= '0;
            end
          end
        end
        S_RD: begin
          state <= (RD_LAT == 1) ? S_WT : S_CAP;
        end
        S_WT: begin
          state <= S_CAP;
        end
        S_CAP: begin
          out_valid <= 1'b1;
          out_addr  <= OMAR;
          out_data  <= OMDR;
          out_inf   <= (OMDR == INF_CODE);
          out_neg   <= 1'b0;
          out_last  <= (OMAR == LAST_ADDR);
          state     <= S_SEND;
        end
        S_SEND: begin
          if (xfer) begin
            out_valid <= 1'b0;
            if (!out_inf) reach_count <= reach_count + 1'b1;
            if (out_last) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              OMAR  <= OMAR + 1'b1;
              state <= S_RD;
            end
          end
        end
        S_NEG: begin
          if (xfer) begin
            out_valid <= 1'b0;
            state     <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bf_result_dumper.sv
// Bench for bf_result_dumper.
// Three instances share the clock and reset:
//   inst 0: DEPTH 4, RD_LAT 0
//   inst 1: DEPTH 4, RD_LAT 1
//   inst 2: DEPTH 8 with ADDR_W 3, i.e. the full address space
// Expected records are built from the memory contents as a list of per-address records.
module tb_bf_result_dumper;
  localparam int              AW  = 3;
  localparam int              DW  = 16;
  localparam logic [DW-1:0]   INF = 16'hFFFF;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          i;
    logic          ng;
    logic          l;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          finish [3];
  logic          negc   [3];
  logic          ready  [3];
  logic [AW-1:0] omar   [3];
  logic          valid  [3];
  logic [AW-1:0] oaddr  [3];
  logic [DW-1:0] odata  [3];
  logic          inf    [3];
  logic          neg    [3];
  logic          last   [3];
  logic [AW:0]   reach  [3];
  logic          busy   [3];
  logic          done   [3];
  logic [DW-1:0] mem    [3][8];

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int LAT = (g == 1) ? 1 : 0;
    logic [DW-1:0] rd;
    if (LAT == 1) begin : gl
      always @(posedge clk) rd <= mem[g][omar[g]];
    end else begin : gc
      assign rd = mem[g][omar[g]];
    end
    bf_result_dumper #(
      .DATA_W(DW), .ADDR_W(AW), .DEPTH((g == 2) ? 8 : 4), .INF_CODE(INF), .RD_LAT(LAT)
    ) u (
      .clock(clk), .reset(rst_n), .Finish(finish[g]), .NegCycle(negc[g]),
      .OMAR(omar[g]), .OMDR(rd), .out_valid(valid[g]), .out_ready(ready[g]),
      .out_addr(oaddr[g]), .out_data(odata[g]), .out_inf(inf[g]), .out_neg(neg[g]),
      .out_last(last[g]), .reach_count(reach[g]), .busy(busy[g]), .done(done[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All 32 output bits of instance k must be zero.
  task automatic chk_zero(input int k, input string tag);
    chk(tag, {omar[k], valid[k], oaddr[k], odata[k], inf[k], neg[k], last[k],
              reach[k], busy[k], done[k]}, 32'h0);
  endtask

  task automatic fill_random(input int k);
    for (int a = 0; a < 8; a++)
      mem[k][a] = ($urandom_range(0, 3) == 0) ? INF : 16'($urandom);
  endtask

  // mode 0: ready always 1, with timing checks
  // mode 1: random ready
  // mode 2: ready held low for 5 cycles on addr 2
  // stop_after >= 0 returns after that many transfers, without end checks.
  task automatic run_drain(input int k, input bit negm, input int mode, input int stop_after);
    rec_t          exp_q[$];
    rec_t          r;
    rec_t          o;
    rec_t          held;
    bit            hold;
    bit            seen;
    bit            rdy;
    int            depth;
    int            lat;
    int            n;
    int            idx;
    int            last_n;
    int            stall;
    int            reach_m;
    logic [AW-1:0] omar0;

    depth = (k == 2) ? 8 : 4;
    lat   = (k == 1) ? 1 : 0;
    if (negm) begin
      r = '{a: '0, d: '0, i: 1'b0, ng: 1'b1, l: 1'b1};
      exp_q.push_back(r);
    end else begin
      for (int a = 0; a < depth; a++) begin
        r = '{a: AW'(a), d: mem[k][a], i: (mem[k][a] == INF), ng: 1'b0, l: (a == depth - 1)};
        exp_q.push_back(r);
      end
    end

    @(negedge clk);
    finish[k] = 1'b0;
    ready[k]  = 1'b0;
    @(negedge clk);
    finish[k] = 1'b1;
    negc[k]   = negm;
    omar0     = omar[k];

    n = 0; idx = 0; reach_m = 0; seen = 0; stall = 0; hold = 0; last_n = 0; held = '0;

    while (idx < exp_q.size() && idx != stop_after) begin
      @(negedge clk);
      n++;
      if (n > 300) begin
        chk($sformatf("timeout_k%0d", k), idx, exp_q.size());
        break;
      end
      if (n == 1) begin
        chk("busy_after_trigger", busy[k], 1);
        chk("done_after_trigger", done[k], 0);
        chk("omar_after_trigger", omar[k], negm ? omar0 : 3'd0);
        negc[k] = ~negm;
      end
      if (n == 4) finish[k] = 1'b0;
      if (n == 7) finish[k] = 1'b1;
      if (negm) chk("neg_omar_static", omar[k], omar0);
      if (valid[k] && !seen) begin
        seen = 1;
        chk("first_valid_cycle", n, negm ? 1 : 3 + lat);
      end
      o = {oaddr[k], odata[k], inf[k], neg[k], last[k]};
      if (hold) begin
        chk("stall_valid", valid[k], 1);
        chk("stall_fields", o, held);
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: begin
          rdy = !(valid[k] && oaddr[k] == 3'd2 && stall < 5);
          if (!rdy) stall++;
        end
      endcase
      ready[k] = rdy;
      if (valid[k] && rdy) begin
        chk($sformatf("rec_k%0d_i%0d", k, idx), o, exp_q[idx]);
        chk("reach_at_xfer", reach[k], reach_m);
        if (!exp_q[idx].i && !exp_q[idx].ng) reach_m++;
        if (mode == 0 && idx > 0) chk("record_spacing", n - last_n, 3 + lat);
        last_n = n;
        idx++;
        hold = 0;
      end else if (valid[k]) begin
        hold = 1;
        held = o;
        chk("reach_while_stalled", reach[k], reach_m);
      end else begin
        hold = 0;
      end
    end

    @(negedge clk);
    ready[k] = 1'b0;
    if (idx != stop_after) begin
      chk("done_at_end", done[k], 1);
      chk("busy_at_end", busy[k], 0);
      chk("valid_at_end", valid[k], 0);
      chk("reach_at_end", reach[k], reach_m);
      if (mode == 2) chk("stall_cycles", stall, 5);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      finish[k] = 1'b0;
      negc[k]   = 1'b0;
      ready[k]  = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      mem[k][0] = 16'd5;
      mem[k][1] = INF;
      mem[k][2] = 16'd0;
      mem[k][3] = 16'd7;
      for (int a = 4; a < 8; a++) mem[k][a] = 16'd0;
    end
    fill_random(2);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) chk_zero(k, $sformatf("reset_state_k%0d", k));
    rst_n = 1'b1;

    // Directed memory {5, INF, 0, 7}: combinational then registered read.
    run_drain(0, 0, 0, -1);
    chk("t1_reach_total", reach[0], 3);
    run_drain(1, 0, 0, -1);
    chk("t2_reach_total", reach[1], 3);

    // Negative-cycle report.
    run_drain(0, 1, 0, -1);
    chk("t3_neg_reach", reach[0], 0);

    // Back-pressure on addr 2.
    run_drain(0, 0, 2, -1);

    // Reset mid-drain after 2 records, then a full restart.
    run_drain(2, 0, 1, 2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero(2, "reset_mid_drain");
    @(negedge clk);
    rst_n = 1'b1;
    run_drain(2, 0, 0, -1);

    // Finish already high when reset releases: no drain may start.
    @(negedge clk);
    rst_n     = 1'b0;
    finish[0] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("no_trigger_at_reset_release", {busy[0], valid[0]}, 2'b00);
    end

    // Full address space: DEPTH 8, ADDR_W 3, last at addr 7. Finish stays high afterwards.
    fill_random(2);
    run_drain(2, 0, 0, -1);
    chk("t6_last_addr", oaddr[2], 7);
    repeat (4) begin
      @(negedge clk);
      chk("hold_done_finish_high", {done[2], busy[2], valid[2]}, 3'b100);
    end

    // Randomised drains across instances with random back-pressure.
    for (int t = 0; t < 8; t++) begin
      int k;
      k = $urandom_range(0, 2);
      fill_random(k);
      run_drain(k, ($urandom_range(0, 3) == 0), 1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
